// File: rtl/hpdcache_mem_resp_read_upsizer.sv
// Narrow-to-wide read-response upsizer for the HPDcache refill port.
// Optional statistics counters are enabled by HPDCACHE_MEM_RESP_UPSIZER_STATS_EN.
module hpdcache_mem_resp_read_upsizer #(
    parameter int unsigned NARROW_W = 64,
    parameter int unsigned WIDE_W   = 512,
    parameter int unsigned ID_W     = 7
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [NARROW_W-1:0] in_data_i,
    input  logic [ID_W-1:0]     in_id_i,
    input  logic                in_error_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [WIDE_W-1:0]   out_data_o,
    output logic [ID_W-1:0]     out_id_o,
    output logic                out_error_o,
    output logic                out_last_o
`ifdef HPDCACHE_MEM_RESP_UPSIZER_STATS_EN
    ,
    output logic [31:0]         stat_words_o,
    output logic [31:0]         stat_stall_o
`endif
);

    localparam int unsigned RATIO = WIDE_W / NARROW_W;
    localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    typedef enum logic {
        FILL,
        FULL
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WIDE_W-1:0]   asm_q;
    logic [WIDE_W-1:0]   merged;
    logic [ID_W-1:0]     id_q;
    logic                err_q;
    logic [ID_W-1:0]     word_id;
    logic                word_err;
    logic                complete;
    logic                stall;
    logic                accept;

    assign complete    = (cnt == LAST_LANE) || in_last_i;
    assign stall       = (state == FULL) && !out_ready_i;
    // Only the completing beat needs a free output register; earlier beats
    // of the next word keep flowing into the assembly buffer.
    assign in_ready_o  = !(stall && complete);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state == FULL);

    assign word_id  = (cnt == '0) ? in_id_i : id_q;
    assign word_err = (cnt == '0) ? in_error_i : (err_q | in_error_i);

    always_comb begin
        merged = asm_q;
        merged[cnt*NARROW_W +: NARROW_W] = in_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= FILL;
            cnt         <= '0;
            asm_q       <= '0;
            id_q        <= '0;
            err_q       <= 1'b0;
            out_data_o  <= '0;
            out_id_o    <= '0;
            out_error_o <= 1'b0;
            out_last_o  <= 1'b0;
        end else begin
            if (accept && complete) begin
                state       <= FULL;
                out_data_o  <= merged;
                out_id_o    <= word_id;
                out_error_o <= word_err;
                out_last_o  <= in_last_i;
                asm_q       <= '0;
                cnt         <= '0;
            end else begin
                if (accept) begin
                    asm_q <= merged;
                    id_q  <= word_id;
                    err_q <= word_err;
                    cnt   <= cnt + CNT_W'(1);
                end
                if ((state == FULL) && out_ready_i) begin
                    state <= FILL;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && accept && (cnt != '0)) begin
            assert (in_id_i == id_q);
        end
    end

`ifdef HPDCACHE_MEM_RESP_UPSIZER_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_words_o <= '0;
            stat_stall_o <= '0;
        end else begin
            if (out_valid_o && out_ready_i && (stat_words_o != '1)) begin
                stat_words_o <= stat_words_o + 32'd1;
            end
            if (in_valid_i && !in_ready_o && (stat_stall_o != '1)) begin
                stat_stall_o <= stat_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hpdcache_mem_resp_read_upsizer.sv
// Scoreboard bench for hpdcache_mem_resp_read_upsizer: transactions are split
// into expected wide words up front, a negedge monitor pops and compares.
module tb_hpdcache_mem_resp_read_upsizer;

    localparam int unsigned NW = 64;
    localparam int unsigned WW = 512;
    localparam int unsigned IW = 7;
    localparam int unsigned R  = WW / NW;

    typedef struct {
        logic [WW-1:0] data;
        logic [IW-1:0] id;
        logic          err;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NW-1:0] in_data = '0;
    logic [IW-1:0] in_id = '0;
    logic          in_error = 1'b0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_data;
    logic [IW-1:0] out_id;
    logic          out_error;
    logic          out_last;
`ifdef HPDCACHE_MEM_RESP_UPSIZER_STATS_EN
    logic [31:0]   stat_words;
    logic [31:0]   stat_stall;
`endif

    word_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    completed = 0;
    int    drained = 0;
    int    drained_base = 0;
    int    lane = 0;
    int    stalls = 0;
    int    rdy_mode = 1;
    bit    hs = 1'b0;
    bit    prev_hold = 1'b0;
    word_t prev;

    hpdcache_mem_resp_read_upsizer #(
        .NARROW_W(NW),
        .WIDE_W  (WW),
        .ID_W    (IW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_id_i    (in_id),
        .in_error_i (in_error),
        .in_last_i  (in_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_id_o   (out_id),
        .out_error_o(out_error),
        .out_last_o (out_last)
`ifdef HPDCACHE_MEM_RESP_UPSIZER_STATS_EN
        ,
        .stat_words_o(stat_words),
        .stat_stall_o(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 9) < 7);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: output valid must match the model's pending count, held words
    // must stay stable, and every handshake pops one expected word.
    always @(negedge clk) begin
        word_t e;
        if (rst) begin
            hs = 1'b0;
            prev_hold = 1'b0;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL valid_in_reset: got %b want 0", out_valid);
            end
        end else begin
            n_vec++;
            if (out_valid !== (completed != drained)) begin
                n_err++;
                $display("FAIL out_valid: got %b want %b", out_valid, completed != drained);
            end
            if (prev_hold) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== prev.data || out_id !== prev.id ||
                    out_error !== prev.err || out_last !== prev.last) begin
                    n_err++;
                    $display("FAIL hold: got v%b id %h err %b last %b want v1 id %h err %b last %b",
                             out_valid, out_id, out_error, out_last, prev.id, prev.err, prev.last);
                end
            end
            hs = out_valid && out_ready;
            if (hs) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: got id %h data %h want none", out_id, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_id !== e.id || out_error !== e.err ||
                        out_last !== e.last) begin
                        n_err++;
                        $display("FAIL word: got id %h err %b last %b data %h want id %h err %b last %b data %h",
                                 out_id, out_error, out_last, out_data, e.id, e.err, e.last, e.data);
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev.data = out_data;
            prev.id   = out_id;
            prev.err  = out_error;
            prev.last = out_last;
        end
    end

    always @(posedge clk) begin
        if (hs) drained++;
    end

    task automatic send_beat(input logic [NW-1:0] d, input logic [IW-1:0] id,
                             input logic e, input logic l);
        int   waited;
        bit   acc;
        logic exp_rdy;
        waited   = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_id    = id;
        in_error = e;
        in_last  = l;
        while (!acc) begin
            @(negedge clk);
            exp_rdy = !((completed != drained) && !out_ready && ((lane == R - 1) || l));
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL in_ready: got %b want %b (lane %0d)", in_ready, exp_rdy, lane);
            end
            acc = (in_ready === 1'b1);
            if (!acc) stalls++;
            @(posedge clk);
            if (acc) begin
                if ((lane == R - 1) || l) begin
                    completed++;
                    lane = 0;
                end else begin
                    lane++;
                end
            end else begin
                waited++;
                if (waited > 200) begin
                    n_err++;
                    $display("FAIL beat_timeout: got no accept in %0d cycles want accept", waited);
                    acc = 1'b1;
                end
            end
            #1;
        end
        in_valid = 1'b0;
        in_error = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference: a transaction of len beats becomes ceil(len/R) words, lane k
    // of word w holding beat w*R+k, unused lanes zero, last only on the final word.
    task automatic send_txn(input int len, input logic [IW-1:0] id, input logic [31:0] errmask,
                            input logic [NW-1:0] base, input bit rnd);
        logic [NW-1:0] beats[$];
        word_t         x;
        for (int k = 0; k < len; k++) begin
            if (rnd) beats.push_back({$urandom, $urandom});
            else     beats.push_back(base + NW'(k));
        end
        for (int w = 0; w * R < len; w++) begin
            x.data = '0;
            x.err  = 1'b0;
            x.id   = id;
            for (int k = w * R; k < len && k < (w + 1) * R; k++) begin
                x.data[(k - w * R) * NW +: NW] = beats[k];
                x.err = x.err | errmask[k];
            end
            x.last = ((w + 1) * R >= len);
            exp_q.push_back(x);
        end
        for (int k = 0; k < len; k++) begin
            send_beat(beats[k], id, errmask[k], k == len - 1);
            if (rnd && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || completed != drained) && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_vec++;
        if (exp_q.size() != 0 || completed != drained) begin
            n_err++;
            $display("FAIL drain: got %0d words outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        int st0;
        logic [31:0] emask;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Full word at full throughput: no stalls expected.
        rdy_mode = 1;
        st0 = stalls;
        send_txn(8, 7'h15, 32'h0, 64'h0, 1'b0);
        wait_idle();
        n_vec++;
        if (stalls != st0) begin
            n_err++;
            $display("FAIL no_stall: got %0d stall cycles want 0", stalls - st0);
        end

        // Early last, then error isolated to one word.
        send_txn(3, 7'h0b, 32'h0, 64'hA, 1'b0);
        send_txn(8, 7'h41, 32'h10, 64'h200, 1'b0);
        send_txn(8, 7'h42, 32'h0, 64'h300, 1'b0);
        wait_idle();

        // Two words with the output blocked: beat 15 must stall.
        st0 = stalls;
        fork
            begin
                rdy_mode = 2;
                repeat (20) @(posedge clk);
                rdy_mode = 1;
            end
            send_txn(16, 7'h2a, 32'h0, 64'h1000, 1'b0);
        join
        wait_idle();
        n_vec++;
        if (stalls == st0) begin
            n_err++;
            $display("FAIL stall_seen: got 0 stall cycles want >0");
        end

        // Reset mid-word discards the partial word.
        for (int k = 0; k < 5; k++) send_beat(64'h50 + NW'(k), 7'h22, 1'b0, 1'b0);
        rst = 1'b1;
        lane = 0;
        completed = drained;
        drained_base = drained;
        stalls = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_txn(8, 7'h33, 32'h0, 64'h100, 1'b0);
        wait_idle();

        // Randomized traffic with random backpressure.
        rdy_mode = 0;
        for (int t = 0; t < 40; t++) begin
            emask = '0;
            for (int k = 0; k < 20; k++) emask[k] = ($urandom_range(0, 7) == 0);
            send_txn($urandom_range(1, 20), IW'($urandom), emask, '0, 1'b1);
        end
        wait_idle();

`ifdef HPDCACHE_MEM_RESP_UPSIZER_STATS_EN
        @(negedge clk);
        n_vec++;
        if (stat_words !== 32'(drained - drained_base)) begin
            n_err++;
            $display("FAIL stat_words: got %0d want %0d", stat_words, drained - drained_base);
        end
        n_vec++;
        if (stat_stall !== 32'(stalls)) begin
            n_err++;
            $display("FAIL stat_stall: got %0d want %0d", stat_stall, stalls);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
